// File: rtl/iir_inverse.sv
// iir_inverse: recovers x[n] = (y[n] - A*y[n-1]) / B from a first-order IIR
// output stream; two-stage valid-qualified pipeline with inexact/sat flags.
//
// Ports:
//   clk, rst_n (async, active low), clr (sync clear)
//   in_valid, data_in[IN_W]          : filtered sample y[n]
//   out_valid, data_out[OUT_W]       : recovered sample x[n]
//   inexact, sat                     : per-output flags
//   err_sticky                       : held until clr or reset
module iir_inverse #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int COEF_W = 8,
  parameter int A      = -1,
  parameter int B      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    inexact,
  output logic                    sat,
  output logic                    err_sticky
);

  localparam int DW = IN_W + COEF_W + 1;

  localparam logic signed [DW-1:0] A_X  = DW'(A);
  localparam logic signed [DW-1:0] B_X  = DW'(B);
  localparam logic signed [DW-1:0] QMAX = DW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] QMIN = ~QMAX;

  if (B == 0) begin : g_bad_b
    $error("iir_inverse: B must be nonzero");
  end

  logic signed [IN_W-1:0]  y_prev_q;
  logic signed [DW-1:0]    d_q;
  logic                    v1_q;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] data_out_q;
  logic                    inexact_q;
  logic                    sat_q;
  logic                    err_q;

  logic signed [DW-1:0]    y_x;
  logic signed [DW-1:0]    yp_x;
  logic signed [DW-1:0]    d_d;
  logic signed [DW-1:0]    q;
  logic signed [DW-1:0]    r;
  logic signed [OUT_W-1:0] data_out_d;
  logic                    sat_d;
  logic                    inexact_d;

  // Full-width operands: the 24-bit product plus a 16-bit term
  // cannot overflow 25 bits.
  assign y_x  = DW'(data_in);
  assign yp_x = DW'(y_prev_q);
  assign d_d  = y_x - A_X * yp_x;

  // Signed / and % truncate toward zero; remainder follows d.
  assign q = d_q / B_X;
  assign r = d_q % B_X;

  always_comb begin
    sat_d      = 1'b0;
    inexact_d  = (r != '0);
    data_out_d = OUT_W'(q);
    if (q > QMAX) begin
      sat_d      = 1'b1;
      data_out_d = OUT_W'(QMAX);
    end else if (q < QMIN) begin
      sat_d      = 1'b1;
      data_out_d = OUT_W'(QMIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_prev_q    <= '0;
      d_q         <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      inexact_q   <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (clr) begin
      y_prev_q    <= '0;
      d_q         <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      inexact_q   <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        d_q      <= d_d;
        y_prev_q <= data_in;
      end
      out_valid_q <= v1_q;
      if (v1_q) begin
        data_out_q <= data_out_d;
        sat_q      <= sat_d;
        inexact_q  <= inexact_d;
        err_q      <= err_q | sat_d | inexact_d;
      end else begin
        sat_q      <= 1'b0;
        inexact_q  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign inexact    = inexact_q;
  assign sat        = sat_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_iir_inverse.sv
// tb_iir_inverse: directed checks of iir_inverse (A=-1, B=4).
// Expected values are hand computed from x = (y + y_prev) / 4.
module tb_iir_inverse;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic signed [15:0] data_in;
  logic              out_valid;
  logic signed [7:0] data_out;
  logic              inexact;
  logic              sat;
  logic              err_sticky;

  int checks = 0;
  int errors = 0;

  iir_inverse #(
    .IN_W(16), .OUT_W(8), .COEF_W(8), .A(-1), .B(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .inexact    (inexact),
    .sat        (sat),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input int y);
    in_valid = 1'b1;
    data_in  = 16'(y);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    data_in  = '0;
  endtask

  task automatic chk_out(input string tag, input int v, input int d,
                         input int ix, input int st, input int er);
    chk({tag, "_ov"}, 32'(out_valid), v);
    chk({tag, "_do"}, 32'(data_out), d);
    chk({tag, "_ix"}, 32'(inexact), ix);
    chk({tag, "_sat"}, 32'(sat), st);
    chk({tag, "_err"}, 32'(err_sticky), er);
  endtask

  int yp;
  int ys[15];
  int xs[15];

  initial begin
    rst_n    = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    #2;
    do_reset();
    chk_out("rst", 0, 0, 0, 0, 0);

    // 12,-20,28 back to back -> 3,-2,2
    send(12);  tick();
    chk("bb_lat", 32'(out_valid), 0);
    send(-20); tick();
    chk_out("bb0", 1, 3, 0, 0, 0);
    send(28);  tick();
    chk_out("bb1", 1, -2, 0, 0, 0);
    idle();    tick();
    chk_out("bb2", 1, 2, 0, 0, 0);
    tick();
    chk("bb_end", 32'(out_valid), 0);

    // 13 -> 3 r1; 39 -> d=52 -> 13 exact, sticky held
    do_reset();
    send(13); tick();
    send(39); tick();
    chk_out("inx0", 1, 3, 1, 0, 1);
    idle();   tick();
    chk_out("inx1", 1, 13, 0, 0, 1);
    tick();
    chk_out("inx2", 0, 13, 0, 0, 1);

    // saturation both ways
    do_reset();
    send(1000); tick();
    idle();     tick();
    chk_out("satp", 1, 127, 0, 1, 1);
    do_reset();
    send(-1000); tick();
    idle();      tick();
    chk_out("satn", 1, -128, 0, 1, 1);

    // gap of 5 idle cycles keeps history
    do_reset();
    send(12); tick();
    idle();   tick();
    chk_out("gap_drain", 1, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gap_ov", 32'(out_valid), 0);
      chk("gap_hold", 32'(data_out), 3);
    end
    send(-20); tick();
    chk("gap_pre", 32'(out_valid), 0);
    idle();    tick();
    chk_out("gap_out", 1, -2, 0, 0, 0);

    // clr drops in-flight sample and history
    do_reset();
    send(12);  tick();
    send(-20); tick();
    chk_out("clr_pre", 1, 3, 0, 0, 0);
    idle(); clr = 1'b1; tick();
    clr = 1'b0;
    chk_out("clr_now", 0, 0, 0, 0, 0);
    tick();
    chk("clr_flush", 32'(out_valid), 0);
    send(16); tick();
    idle();   tick();
    chk_out("clr_out", 1, 4, 0, 0, 0);

    // clr wins over a sample in the same cycle
    send(8); clr = 1'b1; tick();
    clr = 1'b0; idle(); tick();
    chk("clr_drop", 32'(out_valid), 0);

    // async reset with a sample in stage 1
    do_reset();
    send(1000); tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst_now", 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    chk_out("arst_a", 0, 0, 0, 0, 0);
    tick();
    chk("arst_b", 32'(out_valid), 0);

    // loopback of x = -7..7 through the forward filter
    do_reset();
    yp = 0;
    for (int i = 0; i < 15; i++) begin
      xs[i] = i - 7;
      ys[i] = 4 * xs[i] - yp;
      yp    = ys[i];
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 15) send(ys[i]);
      else        idle();
      tick();
      if (i >= 1) chk_out("loop", 1, xs[i-1], 0, 0, 0);
      else        chk("loop_lat", 32'(out_valid), 0);
    end
    idle(); tick();
    chk("loop_end", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
